// File: rtl/hex_scan_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hex_scan_display: multiplexed common-anode 7-seg driver for a hex word     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module hex_scan_display #(
  parameter int DIGITS        = 4,
  parameter int DIV           = 50000,
  parameter int BLANK_CYC     = 500,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic [2:0]            digit_idx,
  output logic                  frame_tick
);

  localparam int                CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(DIV - 1);
  localparam logic [2:0]        IDX_LAST = 3'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW != 0}};
  localparam logic [6:0]        SEG_OFF  = 7'h7F;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [4*DIGITS-1:0]   pending_q, pending_d;
  logic                  pend_flag_q, pend_flag_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic [6:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  slot_end;
  logic                  frame_wrap;
  logic [3:0]            cur_nib;
  logic                  cur_forced;
  logic                  upper_zero;
  logic                  in_dead;
  logic                  dark;
  logic [DIGITS-1:0]     onehot;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0001100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Slot counter and digit scan
  always_comb begin
    slot_end     = (cnt_q == CNT_LAST);
    frame_wrap   = slot_end && (idx_q == IDX_LAST);
    cnt_d        = slot_end ? '0 : cnt_q + CW'(1);
    idx_d        = idx_q;
    if (slot_end) begin
      idx_d = frame_wrap ? 3'd0 : idx_q + 3'd1;
    end
    frame_tick_d = frame_wrap;
  end

  // A load coinciding with the frame boundary bypasses the pending buffer.
  always_comb begin
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;
    disp_d      = disp_q;
    if (load) begin
      pending_d = value;
    end
    if (frame_wrap) begin
      pend_flag_d = 1'b0;
      if (load) begin
        disp_d = value;
      end else if (pend_flag_q) begin
        disp_d = pending_q;
      end
    end else if (load) begin
      pend_flag_d = 1'b1;
    end
  end

  // upper_zero accumulates "all nibbles from the top down to k are zero".
  always_comb begin
    cur_nib    = 4'h0;
    cur_forced = 1'b0;
    upper_zero = 1'b1;
    onehot     = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (disp_q[4*k +: 4] == 4'h0);
      if (idx_q == 3'(k)) begin
        cur_nib    = disp_q[4*k +: 4];
        cur_forced = blank_mask[k] || (lz_en && (k != 0) && upper_zero);
        onehot[k]  = 1'b1;
      end
    end
    in_dead = (32'(cnt_q) < 32'(BLANK_CYC));
    dark    = cur_forced || in_dead;
    seg_d   = dark ? SEG_OFF : hex_to_seg(cur_nib);
    an_d    = dark ? AN_OFF : (onehot ^ AN_OFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      pending_q    <= '0;
      pend_flag_q  <= 1'b0;
      disp_q       <= '0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      pend_flag_q  <= pend_flag_d;
      disp_q       <= disp_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hex_scan_display: randomized self-checking bench with frame-level model |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_hex_scan_display;

  localparam int DIGITS    = 4;
  localparam int DIV       = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME     = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0;
  logic        load = 1'b0;
  logic [3:0]  blank_mask = 4'h0;
  logic        lz_en = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [2:0]  digit_idx;
  logic        frame_tick;

  hex_scan_display #(
    .DIGITS(DIGITS), .DIV(DIV), .BLANK_CYC(BLANK_CYC), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .blank_mask(blank_mask), .lz_en(lz_en), .seg(seg), .an(an),
    .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int          vec_cnt = 0;
  int          err_cnt = 0;
  // Model: n = cycles since reset release; shown word, pending word + flag.
  int          n = 0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_pend = 16'h0;
  bit          m_pflag = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (n=%0d)", tag, got, exp, n);
    end
  endtask

  task automatic tick();
    int          k;
    bit          dk;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    bit          e_ft;
    k  = (n / DIV) % DIGITS;
    dk = blank_mask[k] || (lz_en && k != 0 && (m_disp >> (4 * k)) == 0) || ((n % DIV) < BLANK_CYC);
    e_seg = dk ? 7'h7F : seg_tab[(m_disp >> (4 * k)) & 16'hF];
    e_an  = dk ? 4'hF : ~(4'b0001 << k);
    e_ft  = (n % FRAME) == FRAME - 1;
    if (load) begin
      m_pend = value;
      if (e_ft) begin
        m_disp  = value;
        m_pflag = 1'b0;
      end else begin
        m_pflag = 1'b1;
      end
    end else if (e_ft && m_pflag) begin
      m_disp  = m_pend;
      m_pflag = 1'b0;
    end
    n++;
    @(posedge clk);
    #1;
    check_eq("seg", 32'(seg), 32'(e_seg));
    check_eq("an", 32'(an), 32'(e_an));
    check_eq("digit_idx", 32'(digit_idx), 32'((n / DIV) % DIGITS));
    check_eq("frame_tick", 32'(frame_tick), 32'(e_ft));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic to_boundary();
    while ((n % FRAME) != FRAME - 1) tick();
  endtask

  task automatic model_reset();
    n = 0; m_disp = 16'h0; m_pend = 16'h0; m_pflag = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_seg", 32'(seg), 32'h7F);
    check_eq("rst_an", 32'(an), 32'hF);
    check_eq("rst_idx", 32'(digit_idx), 32'h0);
    check_eq("rst_ft", 32'(frame_tick), 32'h0);
    rst_n = 1'b1;
    model_reset();

    // Free-running scan with zero display
    run(2 * FRAME);
    // Mid-frame load of 12A0
    run(5);
    do_load(16'h12A0);
    run(2 * FRAME);
    // Leading-zero suppression
    lz_en = 1'b1;
    do_load(16'h00F0);
    run(2 * FRAME);
    do_load(16'h0000);
    run(2 * FRAME);
    lz_en = 1'b0;
    // Per-digit blanking
    blank_mask = 4'b0100;
    do_load(16'h8888);
    run(2 * FRAME);
    blank_mask = 4'h0;
    // Last load wins; boundary load bypasses pending
    run(3);
    do_load(16'h1111);
    run(4);
    do_load(16'h2222);
    to_boundary();
    do_load(16'h3333);
    run(2 * FRAME + 6);
    // Asynchronous reset mid-slot
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_seg", 32'(seg), 32'h7F);
    check_eq("arst_an", 32'(an), 32'hF);
    check_eq("arst_idx", 32'(digit_idx), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    run(2 * FRAME);
    // Decode sweep on digit 0
    for (int v = 0; v < 16; v++) begin
      do_load(16'(v));
      run(2 * FRAME);
    end
    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom_range(0, 7) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) lz_en = 1'($urandom);
      tick();
    end
    load = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
